// File: rtl/zx8x_tape_player.sv
// Sinclair ZX80/ZX81 cassette signal generator: streams a buffered .o/.p image onto
// the EAR line as 150 us pulse trains (4 pulses = 0, 9 pulses = 1) separated by silent gaps.
module zx8x_tape_player #(
    parameter int          PULSE_TICKS  = 975,
    parameter int          GAP_TICKS    = 8450,
    parameter int          LEADER_TICKS = 3250000,
    parameter logic [7:0]  NAME_BYTE    = 8'hA6
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        stop,
    input  logic        zx81,
    input  logic [13:0] length,
    output logic [13:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    // Counters are loaded with N-1 so each phase spans exactly N ce ticks,
    // the terminal tick included.
    localparam logic [21:0] PULSE_LOAD  = 22'(PULSE_TICKS - 1);
    localparam logic [21:0] GAP_LOAD    = 22'(GAP_TICKS - 1);
    localparam logic [21:0] LEADER_LOAD = 22'(LEADER_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_FETCH, S_LOAD, S_BIT, S_PHI, S_PLO, S_GAP
    } state_t;

    state_t      r_state,      w_state_next;
    logic [21:0] r_ticks,      w_ticks_next;
    logic [3:0]  r_pulses,     w_pulses_next;
    logic [2:0]  r_bits,       w_bits_next;
    logic [13:0] r_index,      w_index_next;
    logic [13:0] r_length,     w_length_next;
    logic [7:0]  r_shift,      w_shift_next;
    logic        r_zx81,       w_zx81_next;
    logic        r_name,       w_name_next;
    logic        r_fetch_wait, w_fetch_wait_next;
    logic        r_done,       w_done_next;

    logic w_tick_end;
    logic w_more_bytes;

    assign w_tick_end   = ce && (r_ticks == 22'd0);
    assign w_more_bytes = ({1'b0, r_index} + 15'd1) < {1'b0, r_length};

    always_ff @(posedge clk_sys) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state      <= S_IDLE;
            r_ticks      <= '0;
            r_pulses     <= '0;
            r_bits       <= '0;
            r_index      <= '0;
            r_length     <= '0;
            r_shift      <= '0;
            r_zx81       <= 1'b0;
            r_name       <= 1'b0;
            r_fetch_wait <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ticks      <= w_ticks_next;
            r_pulses     <= w_pulses_next;
            r_bits       <= w_bits_next;
            r_index      <= w_index_next;
            r_length     <= w_length_next;
            r_shift      <= w_shift_next;
            r_zx81       <= w_zx81_next;
            r_name       <= w_name_next;
            r_fetch_wait <= w_fetch_wait_next;
            r_done       <= w_done_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_next      = r_state;
        w_ticks_next      = r_ticks;
        w_pulses_next     = r_pulses;
        w_bits_next       = r_bits;
        w_index_next      = r_index;
        w_length_next     = r_length;
        w_shift_next      = r_shift;
        w_zx81_next       = r_zx81;
        w_name_next       = r_name;
        w_fetch_wait_next = r_fetch_wait;
        w_done_next       = 1'b0;

        if (ce && (r_ticks != 22'd0))
            w_ticks_next = r_ticks - 22'd1;

        if (stop) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length != 14'd0) begin
                            w_state_next  = S_LEADER;
                            w_ticks_next  = LEADER_LOAD;
                            w_index_next  = '0;
                            w_length_next = length;
                            w_zx81_next   = zx81;
                            w_name_next   = 1'b0;
                        end else begin
                            w_done_next = 1'b1;
                        end
                    end
                end
                S_LEADER: begin
                    if (w_tick_end) begin
                        if (r_zx81) begin
                            w_name_next  = 1'b1;
                            w_state_next = S_LOAD;
                        end else begin
                            w_fetch_wait_next = 1'b0;
                            w_state_next      = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Address is held two cycles so the RAM's registered read settles.
                    w_fetch_wait_next = 1'b1;
                    if (r_fetch_wait)
                        w_state_next = S_LOAD;
                end
                S_LOAD: begin
                    w_shift_next = r_name ? NAME_BYTE : mem_data;
                    w_bits_next  = '0;
                    w_state_next = S_BIT;
                end
                S_BIT: begin
                    w_pulses_next = r_shift[7] ? 4'd9 : 4'd4;
                    w_ticks_next  = PULSE_LOAD;
                    w_state_next  = S_PHI;
                end
                S_PHI: begin
                    if (w_tick_end) begin
                        w_ticks_next = PULSE_LOAD;
                        w_state_next = S_PLO;
                    end
                end
                S_PLO: begin
                    if (w_tick_end) begin
                        w_pulses_next = r_pulses - 4'd1;
                        if (r_pulses == 4'd1) begin
                            w_ticks_next = GAP_LOAD;
                            w_state_next = S_GAP;
                        end else begin
                            w_ticks_next = PULSE_LOAD;
                            w_state_next = S_PHI;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick_end) begin
                        w_shift_next = {r_shift[6:0], 1'b0};
                        w_bits_next  = r_bits + 3'd1;
                        if (r_bits != 3'd7) begin
                            w_state_next = S_BIT;
                        end else if (r_name) begin
                            w_name_next       = 1'b0;
                            w_index_next      = '0;
                            w_fetch_wait_next = 1'b0;
                            w_state_next      = S_FETCH;
                        end else if (w_more_bytes) begin
                            w_index_next      = r_index + 14'd1;
                            w_fetch_wait_next = 1'b0;
                            w_state_next      = S_FETCH;
                        end else begin
                            w_done_next  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign mem_addr = r_index;
    assign tape_out = (r_state == S_PHI);
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule
